// File: rtl/sm_ingress_arbiter_pkg.sv
// Shared front-end types: metadata word, matcher beat geometry and arbiter FSM encodings.
package struct_s;
  localparam int META_WIDTH = 64;
  typedef logic [META_WIDTH-1:0] metadata_t;

  localparam int SM_DATA_W  = 256;
  localparam int SM_EMPTY_W = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
endpackage

// File: rtl/sm_ingress_arbiter_rr_arbiter.sv
// Round-robin first-set search: the lowest request at or after ptr (circular) wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the closest request to ptr is the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = |req;
    sum       = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/sm_ingress_arbiter.sv
// Packet-level round-robin arbiter feeding one string_matcher from NUM_PORTS ingress streams.
module sm_ingress_arbiter
  import struct_s::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = SM_DATA_W,
  parameter int EMPTY_W   = SM_EMPTY_W,
  parameter int META_W    = META_WIDTH,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS*DATA_W-1:0]  in_pkt_data,
  input  logic [NUM_PORTS-1:0]         in_pkt_valid,
  input  logic [NUM_PORTS-1:0]         in_pkt_sop,
  input  logic [NUM_PORTS-1:0]         in_pkt_eop,
  input  logic [NUM_PORTS*EMPTY_W-1:0] in_pkt_empty,
  output logic [NUM_PORTS-1:0]         in_pkt_ready,
  input  logic [NUM_PORTS*META_W-1:0]  in_meta_data,
  input  logic [NUM_PORTS-1:0]         in_meta_valid,
  output logic [NUM_PORTS-1:0]         in_meta_ready,
  output logic [DATA_W-1:0]            out_pkt_data,
  output logic                         out_pkt_valid,
  output logic                         out_pkt_sop,
  output logic                         out_pkt_eop,
  output logic [EMPTY_W-1:0]           out_pkt_empty,
  output logic [META_W-1:0]            out_meta_data,
  output logic                         out_meta_valid,
  input  logic                         out_almost_full,
  output logic [IDX_W-1:0]             out_port,
  output logic                         err_sop_mid,
  output logic [31:0]                  pkt_cnt
);
  logic [DATA_W-1:0]  data_arr  [NUM_PORTS];
  logic [EMPTY_W-1:0] empty_arr [NUM_PORTS];
  logic [META_W-1:0]  meta_arr  [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign data_arr[gi]  = in_pkt_data[gi*DATA_W +: DATA_W];
    assign empty_arr[gi] = in_pkt_empty[gi*EMPTY_W +: EMPTY_W];
    assign meta_arr[gi]  = in_meta_data[gi*META_W +: META_W];
  end

  logic [1:0]           state_reg;
  logic [IDX_W-1:0]     gnt_reg;
  logic [IDX_W-1:0]     ptr_reg;
  logic [31:0]          pkt_cnt_reg;
  logic                 err_reg;
  logic [DATA_W-1:0]    data_reg;
  logic                 valid_reg;
  logic                 sop_reg;
  logic                 eop_reg;
  logic [EMPTY_W-1:0]   empty_reg;
  logic [META_W-1:0]    meta_reg;
  logic                 meta_valid_reg;
  logic [IDX_W-1:0]     port_reg;

  // A port is only eligible when its SOP beat and its metadata word are both waiting.
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [IDX_W-1:0]     ptr_next;

  assign req      = in_pkt_valid & in_pkt_sop & in_meta_valid;
  assign ptr_next = (arb_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  logic             accept;
  logic             new_grant;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    in_pkt_ready  = '0;
    in_meta_ready = '0;
    accept        = 1'b0;
    new_grant     = 1'b0;
    sel_idx       = gnt_reg;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: begin
          sel_idx = arb_idx;
          if (arb_any && !out_almost_full) begin
            new_grant     = 1'b1;
            accept        = 1'b1;
            in_pkt_ready  = arb_grant;
            in_meta_ready = arb_grant;
          end
        end
        ST_PKT: begin
          in_pkt_ready[gnt_reg] = !out_almost_full;
          accept                = in_pkt_valid[gnt_reg] && !out_almost_full;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      gnt_reg        <= '0;
      ptr_reg        <= '0;
      pkt_cnt_reg    <= '0;
      err_reg        <= 1'b0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      sop_reg        <= 1'b0;
      eop_reg        <= 1'b0;
      empty_reg      <= '0;
      meta_reg       <= '0;
      meta_valid_reg <= 1'b0;
      port_reg       <= '0;
    end else begin
      valid_reg      <= accept;
      meta_valid_reg <= new_grant;
      if (accept) begin
        data_reg  <= data_arr[sel_idx];
        sop_reg   <= in_pkt_sop[sel_idx];
        eop_reg   <= in_pkt_eop[sel_idx];
        empty_reg <= empty_arr[sel_idx];
        port_reg  <= sel_idx;
      end
      if (new_grant) begin
        meta_reg <= meta_arr[sel_idx];
      end
      case (state_reg)
        ST_IDLE: begin
          if (new_grant) begin
            gnt_reg     <= arb_idx;
            ptr_reg     <= ptr_next;
            pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
            state_reg   <= in_pkt_eop[arb_idx] ? ST_GAP : ST_PKT;
          end
        end
        ST_PKT: begin
          // A stray SOP inside a packet is flagged but carried as an ordinary continuation beat.
          if (accept) begin
            if (in_pkt_sop[gnt_reg]) begin
              err_reg <= 1'b1;
            end
            if (in_pkt_eop[gnt_reg]) begin
              state_reg <= ST_GAP;
            end
          end
        end
        ST_GAP:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_pkt_data   = data_reg;
  assign out_pkt_valid  = valid_reg;
  assign out_pkt_sop    = sop_reg;
  assign out_pkt_eop    = eop_reg;
  assign out_pkt_empty  = empty_reg;
  assign out_meta_data  = meta_reg;
  assign out_meta_valid = meta_valid_reg;
  assign out_port       = port_reg;
  assign err_sop_mid    = err_reg;
  assign pkt_cnt        = pkt_cnt_reg;
endmodule

// File: tb/tb_sm_ingress_arbiter.sv
// Scoreboard bench for sm_ingress_arbiter: per-port sources, expected-beat queue, decoupled monitor.
module tb_sm_ingress_arbiter;
  import struct_s::*;

  localparam int NP = 4;
  localparam int DW = SM_DATA_W;
  localparam int EW = SM_EMPTY_W;
  localparam int MW = META_WIDTH;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*DW-1:0] in_pkt_data;
  logic [NP-1:0]    in_pkt_valid;
  logic [NP-1:0]    in_pkt_sop;
  logic [NP-1:0]    in_pkt_eop;
  logic [NP*EW-1:0] in_pkt_empty;
  logic [NP-1:0]    in_pkt_ready;
  logic [NP*MW-1:0] in_meta_data;
  logic [NP-1:0]    in_meta_valid;
  logic [NP-1:0]    in_meta_ready;
  logic [DW-1:0]    out_pkt_data;
  logic             out_pkt_valid;
  logic             out_pkt_sop;
  logic             out_pkt_eop;
  logic [EW-1:0]    out_pkt_empty;
  logic [MW-1:0]    out_meta_data;
  logic             out_meta_valid;
  logic             out_almost_full = 1'b0;
  logic [IW-1:0]    out_port;
  logic             err_sop_mid;
  logic [31:0]      pkt_cnt;

  always #5 clk = ~clk;

  sm_ingress_arbiter #(.NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_sop(in_pkt_sop),
    .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid), .out_pkt_sop(out_pkt_sop),
    .out_pkt_eop(out_pkt_eop), .out_pkt_empty(out_pkt_empty), .out_meta_data(out_meta_data),
    .out_meta_valid(out_meta_valid), .out_almost_full(out_almost_full), .out_port(out_port),
    .err_sop_mid(err_sop_mid), .pkt_cnt(pkt_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic          meta_valid;
    logic [MW-1:0] meta;
    logic [IW-1:0] port;
  } exp_t;

  beat_t         src_q  [NP][$];
  logic [MW-1:0] meta_q [NP][$];
  bit            meta_hold [NP];
  exp_t          exp_q [$];
  int            out_cyc [$];
  int            meta_pops [NP];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            m2_arm = 1'b0;
  int            m2_cyc = 0;
  exp_t          mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mk_data(input int p, input int tag, input int b);
    return {8{p[7:0], tag[7:0], b[15:0]}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic present();
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) begin
        in_pkt_valid[i]           = 1'b1;
        in_pkt_data[i*DW +: DW]   = src_q[i][0].data;
        in_pkt_sop[i]             = src_q[i][0].sop;
        in_pkt_eop[i]             = src_q[i][0].eop;
        in_pkt_empty[i*EW +: EW]  = src_q[i][0].empty;
      end else begin
        in_pkt_valid[i]           = 1'b0;
        in_pkt_data[i*DW +: DW]   = '0;
        in_pkt_sop[i]             = 1'b0;
        in_pkt_eop[i]             = 1'b0;
        in_pkt_empty[i*EW +: EW]  = '0;
      end
      in_meta_valid[i]         = (meta_q[i].size() > 0) && !meta_hold[i];
      in_meta_data[i*MW +: MW] = (meta_q[i].size() > 0) ? meta_q[i][0] : '0;
    end
  endtask

  // Source model: handshakes sampled mid-cycle, queues advanced just after the edge.
  initial begin
    bit ap [NP];
    bit am [NP];
    present();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        ap[i] = in_pkt_valid[i] && in_pkt_ready[i];
        am[i] = in_meta_valid[i] && in_meta_ready[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (rst) begin
          src_q[i].delete();
          meta_q[i].delete();
        end else begin
          if (ap[i]) void'(src_q[i].pop_front());
          if (am[i]) void'(meta_q[i].pop_front());
        end
      end
      present();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        if (in_meta_ready[i]) meta_pops[i]++;
      end
      if (m2_arm && in_meta_valid[2]) begin
        m2_cyc = cyc;
        m2_arm = 1'b0;
      end
      n_tests++;
      if (out_pkt_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: port=%0d sop=%b data=%h", out_port, out_pkt_sop, out_pkt_data);
        end else begin
          mon_e = exp_q.pop_front();
          out_cyc.push_back(cyc);
          if (out_pkt_data !== mon_e.b.data || out_pkt_sop !== mon_e.b.sop ||
              out_pkt_eop !== mon_e.b.eop || out_pkt_empty !== mon_e.b.empty ||
              out_meta_valid !== mon_e.meta_valid || out_meta_data !== mon_e.meta ||
              out_port !== mon_e.port) begin
            n_fail++;
            $display("FAIL sb_beat: got port=%0d sop=%b eop=%b empty=%0d mv=%b meta=%h data=%h; expected port=%0d sop=%b eop=%b empty=%0d mv=%b meta=%h data=%h",
                     out_port, out_pkt_sop, out_pkt_eop, out_pkt_empty, out_meta_valid, out_meta_data, out_pkt_data,
                     mon_e.port, mon_e.b.sop, mon_e.b.eop, mon_e.b.empty, mon_e.meta_valid, mon_e.meta, mon_e.b.data);
          end
        end
      end else if (out_meta_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL meta_valid_idle: got %b expected 0", out_meta_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int p, input int nb, input logic [MW-1:0] meta, input int tag,
                      input logic [EW-1:0] last_empty, input int extra_sop, input bit has_eop);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < nb; k++) begin
      b.data  = mk_data(p, tag, k);
      b.sop   = (k == 0) || (k == extra_sop);
      b.eop   = has_eop && (k == nb - 1);
      b.empty = b.eop ? last_empty : '0;
      src_q[p].push_back(b);
      e.b          = b;
      e.meta_valid = (k == 0);
      e.meta       = meta;
      e.port       = IW'(p);
      exp_q.push_back(e);
    end
    meta_q[p].push_back(meta);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      tick();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int k;
    for (int i = 0; i < NP; i++) begin
      meta_hold[i] = 1'b0;
      meta_pops[i] = 0;
    end
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 64'(out_pkt_valid), 64'd0);
    check("rst_meta_valid", 64'(out_meta_valid), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_err", 64'(err_sop_mid), 64'd0);
    check("rst_ready", 64'({in_pkt_ready, in_meta_ready}), 64'd0);
    rst = 1'b0;
    tick();

    // All four ports request single-beat packets; port 0 has a second one queued.
    out_cyc.delete();
    for (int p = 0; p < NP; p++) send(p, 1, 64'h100 + 64'(p), 8'h20 + p, 5'd3, -1, 1'b1);
    send(0, 1, 64'h104, 8'h24, 5'd3, -1, 1'b1);
    drain("t2_drain");
    check("t2_count", 64'(out_cyc.size()), 64'd5);
    if (out_cyc.size() == 5) begin
      for (int i = 1; i < 5; i++) check("t2_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'd2);
    end
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'd5);

    // Port 0 alone, 3-beat packet with metadata A5.
    out_cyc.delete();
    snap = meta_pops[0];
    send(0, 3, 64'hA5, 8'h10, 5'd0, -1, 1'b1);
    drain("t1_drain");
    check("t1_count", 64'(out_cyc.size()), 64'd3);
    if (out_cyc.size() == 3) check("t1_back_to_back", 64'(out_cyc[2] - out_cyc[0]), 64'd2);
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd6);
    check("t1_meta_pops", 64'(meta_pops[0] - snap), 64'd1);

    // Port 2 waits for its metadata while port 1 is served.
    out_cyc.delete();
    meta_hold[2] = 1'b1;
    snap = meta_pops[2];
    send(1, 1, 64'h11, 8'h30, 5'd1, -1, 1'b1);
    send(2, 2, 64'h22, 8'h31, 5'd2, -1, 1'b1);
    repeat (10) tick();
    check("t3_no_early_pop", 64'(meta_pops[2] - snap), 64'd0);
    check("t3_port2_pending", 64'(exp_q.size()), 64'd2);
    m2_arm = 1'b1;
    meta_hold[2] = 1'b0;
    drain("t3_drain");
    if (out_cyc.size() == 3) check("t3_grant_after_meta", 64'(out_cyc[1] - m2_cyc), 64'd1);
    else check("t3_count", 64'(out_cyc.size()), 64'd3);
    check("t3_meta_pops", 64'(meta_pops[2] - snap), 64'd1);
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // 6-beat packet on port 3 stalled by almost_full while port 0 competes.
    send(3, 6, 64'h33, 8'h40, 5'd7, -1, 1'b1);
    send(0, 1, 64'h44, 8'h41, 5'd1, -1, 1'b1);
    k = 0;
    while (exp_q.size() > 5 && k < 50) begin
      tick();
      k++;
    end
    check("t4_started", 64'(exp_q.size() <= 5), 64'd1);
    out_almost_full = 1'b1;
    repeat (4) begin
      #1;
      check("t4_af_pkt_ready", 64'(in_pkt_ready), 64'd0);
      check("t4_af_meta_ready", 64'(in_meta_ready), 64'd0);
      tick();
    end
    out_almost_full = 1'b0;
    drain("t4_drain");

    // Stray SOP mid-packet on port 1, then an immediate follow-up packet.
    check("t5_err_before", 64'(err_sop_mid), 64'd0);
    out_cyc.delete();
    snap = meta_pops[1];
    send(1, 5, 64'h55, 8'h50, 5'd2, 2, 1'b1);
    send(1, 1, 64'h66, 8'h51, 5'd4, -1, 1'b1);
    drain("t5_drain");
    check("t5_err_set", 64'(err_sop_mid), 64'd1);
    check("t5_meta_pops", 64'(meta_pops[1] - snap), 64'd2);
    if (out_cyc.size() == 6) check("t5_gap_after_eop", 64'(out_cyc[5] - out_cyc[4]), 64'd2);
    else check("t5_count", 64'(out_cyc.size()), 64'd6);
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'd12);
    repeat (3) tick();
    check("t5_err_sticky", 64'(err_sop_mid), 64'd1);

    // Reset while port 1 sits mid-packet, then ports 1 and 3 race from ptr 0.
    send(1, 2, 64'h77, 8'h60, 5'd0, -1, 1'b0);
    drain("t6_partial");
    check("t6_pkt_cnt_pre", 64'(pkt_cnt), 64'd13);
    rst = 1'b1;
    tick();
    check("t6_valid", 64'(out_pkt_valid), 64'd0);
    check("t6_data_zero", 64'(out_pkt_data == '0), 64'd1);
    check("t6_sop_eop_empty", 64'({out_pkt_sop, out_pkt_eop, out_pkt_empty}), 64'd0);
    check("t6_meta", 64'(out_meta_data), 64'd0);
    check("t6_meta_valid", 64'(out_meta_valid), 64'd0);
    check("t6_port", 64'(out_port), 64'd0);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t6_err", 64'(err_sop_mid), 64'd0);
    check("t6_ready", 64'({in_pkt_ready, in_meta_ready}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send(1, 1, 64'h81, 8'h70, 5'd0, -1, 1'b1);
    send(3, 1, 64'h83, 8'h71, 5'd0, -1, 1'b1);
    drain("t6_drain");
    check("t6_pkt_cnt_post", 64'(pkt_cnt), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sm_ingress_arbiter.md
Name: sm_ingress_arbiter

Overview:
Packet-level round-robin arbiter that shares one string_matcher front end between NUM_PORTS independent ingress streams. Each stream is 256-bit packet data plus one metadata word per packet.
- Grants a whole packet at a time and pairs each packet's metadata with its SOP beat.
- Inserts the mandatory one-cycle bubble after every EOP.
- Throttles on the matcher's almost-full.
- Sits in the front_clk domain, between the per-port data_shift outputs and the string_matcher input.

Parameters:
NUM_PORTS, 4, number of requesting streams (2..8)
DATA_W, 256, packet beat width in bits
EMPTY_W, 5, empty field width, log2(DATA_W/8)
META_W, META_WIDTH (package), metadata word width

Ports:
clk  in  1  front_clk domain clock
rst  in  1  synchronous active-high reset
in_pkt_data  in  NUM_PORTS*DATA_W  per-port beat; port i occupies bits [i*DATA_W +: DATA_W]
in_pkt_valid  in  NUM_PORTS  per-port beat valid
in_pkt_sop  in  NUM_PORTS  per-port start of packet
in_pkt_eop  in  NUM_PORTS  per-port end of packet
in_pkt_empty  in  NUM_PORTS*EMPTY_W  per-port empty bytes on EOP beat
in_pkt_ready  out  NUM_PORTS  per-port beat accept
in_meta_data  in  NUM_PORTS*META_W  per-port metadata word
in_meta_valid  in  NUM_PORTS  per-port metadata valid
in_meta_ready  out  NUM_PORTS  per-port metadata pop, one-cycle pulse
out_pkt_data  out  DATA_W  granted beat
out_pkt_valid  out  1  beat valid
out_pkt_sop  out  1  start of packet
out_pkt_eop  out  1  end of packet
out_pkt_empty  out  EMPTY_W  empty bytes
out_meta_data  out  META_W  metadata for the packet now starting
out_meta_valid  out  1  asserted on the SOP beat only
out_almost_full  in  1  string_matcher back-pressure
out_port  out  log2(NUM_PORTS)  source port of the current output beat
err_sop_mid  out  1  sticky: granted port sent SOP before EOP
pkt_cnt  out  32  packets granted since reset, wraps

Behaviour:
- Reset: all outputs 0, including in_*_ready, err_sop_mid and pkt_cnt. FSM=IDLE. RR pointer=0. Reset mid-packet abandons the packet; upstream is reset in the same cycle.
- req[i] = in_pkt_valid[i] & in_pkt_sop[i] & in_meta_valid[i]. A port without metadata is never granted.
- IDLE:
  - If any req and !out_almost_full, grant the first requesting port at or after ptr (circular).
  - Same cycle: in_pkt_ready[g]=1 and in_meta_ready[g]=1 (SOP beat and metadata popped together). ptr<=g+1 mod NUM_PORTS. pkt_cnt++.
  - Next state: GAP if the SOP beat is also EOP (single-beat packet), else PKT.
- PKT: in_pkt_ready[g] = !out_almost_full; all other ready bits 0.
  - Accepted beat with eop -> GAP.
  - Accepted beat with sop -> set err_sop_mid; treat the beat as a new packet continuation (no metadata pop); stay in PKT.
- GAP: exactly one cycle, no ready asserted, -> IDLE. The earliest next grant is 2 cycles after the EOP accept.
- Output: registered, latency 1. Cycle after an accept: out_pkt_* = accepted beat, out_pkt_valid=1, out_port=g.
  - On the SOP beat also out_meta_valid=1 and out_meta_data=popped word.
  - With no accept: out_pkt_valid=0 and out_meta_valid=0; data fields hold their last value.
- in_*_ready are combinational from FSM state, grant, out_almost_full and inputs. No combinational path from out_almost_full to out_* .
- out_almost_full asserted in IDLE blocks new grants. Asserted in PKT, it stalls the packet; the grant is held, never preempted. The matcher tolerates 1 beat of skid after almost_full.
- Simultaneous requests: exactly one grant, strict RR. A port requesting continuously is served at most once every NUM_PORTS grants when all ports request.
- pkt_cnt wraps 0xFFFFFFFF -> 0.

Decomposition:
- Shared package (struct_s): META_WIDTH and metadata_t already exist; add SM_DATA_W=256 and SM_EMPTY_W=5.
- One sub-module, rr_arbiter:
  - Combinational first-set search from ptr over a NUM_PORTS request vector.
  - Returns a one-hot grant and its index.
  - Reusable elsewhere in the design.

Test Plan:
1. Port 0 only, 3-beat packet with meta 0xA5 -> out beats on cycles t+1..t+3; out_meta_valid=1 with data 0xA5 only at t+1; out_port=0; pkt_cnt=1.
2. All 4 ports request, 1-beat packets each -> grant order 0,1,2,3,0; consecutive grants 2 cycles apart; pkt_cnt=5.
3. Port 2 has packet valid but in_meta_valid=0 for 10 cycles while port 1 requests -> port 1 served; port 2 granted the cycle after its meta arrives; no meta popped before then.
4. out_almost_full=1 for cycles 2-5 of a 6-beat packet -> in_pkt_ready low during those cycles; no other port granted; all 6 beats in order; out_pkt_empty=7 on EOP when input empty=7.
5. Second SOP mid-packet on granted port -> err_sop_mid=1 and stays 1; no extra in_meta_ready pulse; next EOP returns the FSM to IDLE via GAP.
6. rst asserted in the middle of a PKT beat -> next cycle all outputs 0, ptr=0; a following request on port 3 is granted normally.
